// File: rtl/prod_accumulator.sv
// Purpose: sums BURST unsigned 8-bit products into a saturating ACC_W-bit accumulator and presents the burst result.
// Latency: result_valid rises the cycle after the final accept; the partial sum on acc_out updates one cycle after each accept.
// Backpressure: prod_ready drops while a result is held; it returns the cycle after result_ready or clear is seen.
module prod_accumulator #(
    parameter int ACC_W = 16,
    parameter int BURST = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [7:0]       prod_in,
    input  logic             prod_valid,
    output logic             prod_ready,
    input  logic             clear,
    output logic [ACC_W-1:0] acc_out,
    output logic [3:0]       count,
    output logic             result_valid,
    input  logic             result_ready,
    output logic             ovf
);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] ACCUM = 2'd1;
    localparam logic [1:0] HOLD  = 2'd2;

    localparam logic [3:0] BURST_CNT = 4'(BURST);

    logic [1:0]     state;
    logic           accept;
    logic [ACC_W:0] sum;
    logic [3:0]     count_inc;

    assign prod_ready   = (state != HOLD);
    assign result_valid = (state == HOLD);
    assign accept       = prod_valid && prod_ready;

    // One extra bit catches the carry that triggers saturation.
    assign sum       = {1'b0, acc_out} + {{(ACC_W-7){1'b0}}, prod_in};
    assign count_inc = count + 4'd1;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            acc_out <= '0;
            count   <= '0;
            ovf     <= 1'b0;
        end else if (clear) begin
            state   <= IDLE;
            acc_out <= '0;
            count   <= '0;
            ovf     <= 1'b0;
        end else begin
            case (state)
                IDLE, ACCUM: begin
                    if (accept) begin
                        acc_out <= sum[ACC_W] ? {ACC_W{1'b1}} : sum[ACC_W-1:0];
                        count   <= count_inc;
                        if (sum[ACC_W]) begin
                            ovf <= 1'b1;
                        end
                        state <= (count_inc == BURST_CNT) ? HOLD : ACCUM;
                    end
                end
                HOLD: begin
                    if (result_ready) begin
                        state   <= IDLE;
                        acc_out <= '0;
                        count   <= '0;
                        ovf     <= 1'b0;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/prod_accumulator.md
PROD_ACCUMULATOR -- requirements
Module: prod_accumulator

Interface
REQ-001 Parameter ACC_W, default 16: accumulator width in bits; legal range 9..24.
REQ-002 Parameter BURST, default 4: number of products summed per result; legal range 1..15.
REQ-003 clk  in  1  single clock; all state updates on the rising edge.
REQ-004 rst  in  1  reset, asynchronous, active-high.
REQ-005 prod_in  in  8  unsigned 8-bit product from the 4x4 array multiplier.
REQ-006 prod_valid  in  1  prod_in is valid this cycle.
REQ-007 prod_ready  out  1  block accepts prod_in this cycle.
REQ-008 clear  in  1  synchronous abort: discard the burst and restart.
REQ-009 acc_out  out  ACC_W  running or final sum, registered.
REQ-010 count  out  4  number of products accepted in the current burst.
REQ-011 result_valid  out  1  acc_out holds a completed burst sum.
REQ-012 result_ready  in  1  consumer takes the result.
REQ-013 ovf  out  1  sticky saturation flag for the current burst.

Function
REQ-014 The FSM SHALL have three states: IDLE (count=0, no burst in progress), ACCUM (burst in progress) and HOLD (result presented).
REQ-015 prod_ready SHALL equal 1 in IDLE and ACCUM, and 0 in HOLD; it is a combinational decode of state only and SHALL NOT depend on prod_valid.
REQ-016 An accept occurs when prod_valid=1 and prod_ready=1 on a rising edge.
REQ-017 On an accept: acc_out <= min(acc_out + zero-extended prod_in, 2^ACC_W-1); count <= count+1.
REQ-018 On an accept where the true sum exceeds 2^ACC_W-1, ovf SHALL be set to 1 and remain set until the burst is consumed, cleared or reset.
REQ-019 Transition IDLE->ACCUM on an accept when BURST>1.
REQ-020 Transition to HOLD on the accept that makes count equal BURST; this applies from IDLE when BURST=1, otherwise from ACCUM.
REQ-021 result_valid SHALL equal 1 exactly while in HOLD, so it is first high in the cycle after the final accept (latency 1 cycle).
REQ-022 In HOLD, acc_out, count and ovf SHALL be held stable, and prod_valid SHALL be ignored.
REQ-023 In HOLD with result_ready=1 at a rising edge: acc_out, count and ovf <= 0 and the state goes to IDLE; prod_ready is 1 in the following cycle.
REQ-024 result_ready outside HOLD SHALL have no effect.
REQ-025 prod_valid=0 in ACCUM SHALL hold all state; a burst has no timeout.
REQ-026 If clear=1 at a rising edge in any state: acc_out, count and ovf <= 0 and the state goes to IDLE.
REQ-027 clear SHALL override a simultaneous accept or result handshake, and the product presented in that cycle SHALL be dropped.
REQ-028 acc_out SHALL be visible during ACCUM and show the partial sum after each accept.

Reset
REQ-029 While rst=1, independent of clk: state=IDLE, acc_out=0, count=0, ovf=0, result_valid=0, prod_ready=1.
REQ-030 Assertion of rst mid-burst or in HOLD SHALL immediately discard all state.
REQ-031 The first accept SHALL be possible on the first rising edge after rst deasserts.

Verification
REQ-032 Nominal: BURST=4, ACC_W=16; four back-to-back accepts of 225 (15x15) -> acc_out 225, 450, 675, 900; result_valid=1 on the next cycle with acc_out=900, ovf=0, count=4.
REQ-033 Saturation: ACC_W=9, BURST=4; four accepts of 225 -> acc_out 225, 450, 511, 511; ovf sets on the third accept; result shows 511 with ovf=1.
REQ-034 Backpressure: hold result_ready=0 for 3 cycles in HOLD while prod_valid=1 with prod_in=7 -> prod_ready=0 and acc_out is stable; on result_ready=1, IDLE is entered with acc_out=0, and the next accept of 7 gives acc_out=7.
REQ-035 Clear mid-burst: accept 10 and 20, then assert clear together with prod_valid=1 and prod_in=30 -> next cycle acc_out=0, count=0, IDLE, and 30 is not accumulated.
REQ-036 Async reset: pulse rst between clock edges during ACCUM with acc_out=450 -> outputs go to their reset values before the next edge; a fresh burst of 1,2,3,4 then yields 10.
REQ-037 Bubbles and BURST=1: BURST=4 with prod_valid toggled 1,0,0,1,0,1,1 on values 1..4 -> result 10; with BURST=1, a single accept of 9 -> result_valid next cycle with acc_out=9.
